// File: rtl/aibnd_sigbuf_arb.sv
// Round-robin owner arbiter for the shared sideband signal buffer, with minimum
// tenure and a break-before-make gap. Optional forced release: AIBND_SIGBUF_ARB_TIMEOUT_EN.
module aibnd_sigbuf_arb #(
  parameter int   NREQ       = 4,
  parameter int   MIN_HOLD   = 4,
  parameter int   GAP_CYC    = 2,
  parameter logic IDLE_VAL   = 1'b0,
  parameter int   MAX_TENURE = 64,
  localparam int  IW         = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] sig_in,
  output logic [NREQ-1:0] gnt,
  output logic            sig_out,
  output logic            busy,
  output logic [IW-1:0]   owner_id
`ifdef AIBND_SIGBUF_ARB_TIMEOUT_EN
  ,
  output logic            tmo_evt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MIN_HOLD);
  localparam logic [7:0] GAP_MAX  = 8'(GAP_CYC);

  state_t          state, state_nx;
  logic [NREQ-1:0] gnt_nx;
  logic            sig_nx, busy_nx;
  logic [IW-1:0]   owner_nx, ptr, ptr_nx, pick;
  logic [IW:0]     idx;
  logic            found;
  logic [7:0]      hold_cnt, hold_nx, gap_cnt, gap_nx;
  logic            force_rel;

`ifdef AIBND_SIGBUF_ARB_TIMEOUT_EN
  logic [15:0] ten_cnt, ten_nx;
  logic        tmo_nx;
  // Forced release only matters when someone else is waiting for the path.
  assign force_rel = (ten_cnt >= 16'(MAX_TENURE)) && (|(req & ~gnt));
`else
  assign force_rel = 1'b0;
`endif

  // Rotating search starting at ptr; the sum never exceeds 2*NREQ-2 so one subtract wraps it.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    sig_nx   = sig_out;
    owner_nx = owner_id;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    gap_nx   = gap_cnt;
`ifdef AIBND_SIGBUF_ARB_TIMEOUT_EN
    ten_nx   = ten_cnt;
    tmo_nx   = tmo_evt;
`endif
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nx     = S_GRANT;
          gnt_nx       = '0;
          gnt_nx[pick] = 1'b1;
          owner_nx     = pick;
          ptr_nx       = (pick == IW'(NREQ-1)) ? '0 : pick + 1'b1;
          hold_nx      = 8'd1;
          sig_nx       = sig_in[pick];
`ifdef AIBND_SIGBUF_ARB_TIMEOUT_EN
          ten_nx       = 16'd1;
          tmo_nx       = 1'b0;
`endif
        end
      end
      S_GRANT: begin
        sig_nx = sig_in[owner_id];
        if (hold_cnt < HOLD_MAX) hold_nx = hold_cnt + 8'd1;
`ifdef AIBND_SIGBUF_ARB_TIMEOUT_EN
        if (ten_cnt < 16'(MAX_TENURE)) ten_nx = ten_cnt + 16'd1;
        if (force_rel && req[owner_id]) tmo_nx = 1'b1;
`endif
        if ((!req[owner_id] && hold_cnt >= HOLD_MAX) || force_rel) begin
          state_nx = S_GAP;
          gnt_nx   = '0;
          sig_nx   = IDLE_VAL;
          gap_nx   = 8'd1;
        end
      end
      S_GAP: begin
        sig_nx = IDLE_VAL;
        if (gap_cnt >= GAP_MAX) state_nx = S_IDLE;
        else gap_nx = gap_cnt + 8'd1;
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= '0;
      sig_out  <= IDLE_VAL;
      busy     <= 1'b0;
      owner_id <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
`ifdef AIBND_SIGBUF_ARB_TIMEOUT_EN
      ten_cnt  <= '0;
      tmo_evt  <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      sig_out  <= sig_nx;
      busy     <= busy_nx;
      owner_id <= owner_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      gap_cnt  <= gap_nx;
`ifdef AIBND_SIGBUF_ARB_TIMEOUT_EN
      ten_cnt  <= ten_nx;
      tmo_evt  <= tmo_nx;
`endif
    end
  end

endmodule
